// File: rtl/gmac_rx_frame_buf.sv
// Store-and-forward receive buffer for a GMAC: frames are written byte by
// byte and released to the consumer only once committed with a good EOF.
// Optional frame statistics: define GMAC_RX_FRAME_BUF_STAT_EN.
module gmac_rx_frame_buf #(
  parameter int DEPTH_LOG2 = 11,
  parameter int MIN_FRAME  = 1
) (
  input  logic       clk125,
  input  logic       rst,
  input  logic       ENA_IN,
  input  logic       SOF_IN,
  input  logic       EOF_IN,
  input  logic       ERR_IN,
  input  logic [7:0] DATA_IN,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_sof,
  output logic       o_eof,
  output logic [7:0] o_data,
  output logic       drop_pulse
`ifdef GMAC_RX_FRAME_BUF_STAT_EN
  ,
  output logic [31:0] frames_ok,
  output logic [31:0] frames_drop
`endif
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam int LW = DEPTH_LOG2 + 2;
  localparam logic [PW-1:0] FULL_X = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [31:0] MIN_U = MIN_FRAME;

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

  state_t        state_q;
  logic [PW-1:0] wr_q;
  logic [PW-1:0] commit_q;
  logic [PW-1:0] rd_q;
  logic [LW-1:0] len_q;
  logic          drop_q;

  logic [8:0]    mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [8:0]    rdata_q;
  logic          s1_v_q;
  logic          o_valid_q;
  logic          o_sof_q;
  logic          o_eof_q;
  logic [7:0]    o_data_q;
  logic          sof_pend_q;

  logic          take_d;
  logic          start_d;
  logic          abandon_d;
  logic [PW-1:0] base_d;
  logic [PW-1:0] next_d;
  logic          full_d;
  logic [LW-1:0] len_d;
  logic [31:0]   len32_d;
  logic          ok_d;
  logic          we_d;
  logic          commit_ev_d;
  logic          out_adv_d;
  logic          fetch_d;

  // Write-side decode; a SOF always restarts at the last commit point
  always_comb begin
    take_d = ENA_IN &&
      ((state_q == IDLE && SOF_IN) || state_q == RECV);
    start_d = take_d && SOF_IN;
    abandon_d = take_d && SOF_IN && (state_q == RECV);
    base_d = start_d ? commit_q : wr_q;
    next_d = base_d + PW'(1);
    full_d = ((base_d ^ rd_q) == FULL_X);
    len_d = start_d ? LW'(1) : len_q + LW'(1);
    len32_d = 32'(len_d);
    ok_d = !ERR_IN && (len32_d >= MIN_U);
    we_d = take_d && !full_d;
    commit_ev_d = we_d && EOF_IN && ok_d;
  end

  // Read-side decode: RAM output stage feeds the output register
  always_comb begin
    out_adv_d = !o_valid_q || i_ready;
    fetch_d = (rd_q != commit_q) && (!s1_v_q || out_adv_d);
  end

  // Write FSM: accept, commit, rewind or discard frames
  always_ff @(posedge clk125) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_q     <= '0;
      commit_q <= '0;
      len_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= abandon_d;
      if (take_d) begin
        if (full_d) begin
          wr_q    <= commit_q;
          drop_q  <= 1'b1;
          state_q <= EOF_IN ? IDLE : DISCARD;
        end else if (EOF_IN) begin
          state_q <= IDLE;
          if (ok_d) begin
            wr_q     <= next_d;
            commit_q <= next_d;
          end else begin
            wr_q   <= commit_q;
            drop_q <= 1'b1;
          end
        end else begin
          wr_q    <= next_d;
          len_q   <= len_d;
          state_q <= RECV;
        end
      end else if (state_q == DISCARD && ENA_IN && EOF_IN) begin
        state_q <= IDLE;
      end
    end
  end

  // Frame RAM with registered read port (holds while stalled)
  always_ff @(posedge clk125) begin
    if (we_d)
      mem_q[base_d[DEPTH_LOG2-1:0]] <= {EOF_IN, DATA_IN};
    if (fetch_d)
      rdata_q <= mem_q[rd_q[DEPTH_LOG2-1:0]];
  end

  // Read pipeline: fetch committed bytes, present with frame delimiters
  always_ff @(posedge clk125) begin
    if (rst) begin
      rd_q       <= '0;
      s1_v_q     <= 1'b0;
      o_valid_q  <= 1'b0;
      o_sof_q    <= 1'b0;
      o_eof_q    <= 1'b0;
      o_data_q   <= '0;
      sof_pend_q <= 1'b1;
    end else begin
      if (fetch_d) begin
        rd_q   <= rd_q + PW'(1);
        s1_v_q <= 1'b1;
      end else if (out_adv_d) begin
        s1_v_q <= 1'b0;
      end
      if (out_adv_d) begin
        o_valid_q <= s1_v_q;
        if (s1_v_q) begin
          o_data_q   <= rdata_q[7:0];
          o_eof_q    <= rdata_q[8];
          o_sof_q    <= sof_pend_q;
          sof_pend_q <= rdata_q[8];
        end
      end
    end
  end

  assign o_valid    = o_valid_q;
  assign o_sof      = o_sof_q;
  assign o_eof      = o_eof_q;
  assign o_data     = o_data_q;
  assign drop_pulse = drop_q;

`ifdef GMAC_RX_FRAME_BUF_STAT_EN
  logic [31:0] ok_cnt_q;
  logic [31:0] drop_cnt_q;

  // Wrapping frame statistics
  always_ff @(posedge clk125) begin
    if (rst) begin
      ok_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (commit_ev_d)
        ok_cnt_q <= ok_cnt_q + 32'd1;
      if (drop_q)
        drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign frames_ok   = ok_cnt_q;
  assign frames_drop = drop_cnt_q;
`else
  logic unused_ev;
  assign unused_ev = commit_ev_d;
`endif

endmodule

// File: tb/tb_gmac_rx_frame_buf.sv
// Randomized bench for gmac_rx_frame_buf against a frame-level
// scoreboard of expected output bytes and expected drop count.
module tb_gmac_rx_frame_buf;

  localparam int DL    = 6;
  localparam int DEPTH = 1 << DL;
  localparam int MINF  = 2;

  logic       clk;
  logic       rst;
  logic       ena, sof, eof, err;
  logic [7:0] din;
  logic       o_valid, i_ready, o_sof, o_eof, drop_pulse;
  logic [7:0] o_data;
`ifdef GMAC_RX_FRAME_BUF_STAT_EN
  logic [31:0] frames_ok, frames_drop;
`endif

  gmac_rx_frame_buf #(.DEPTH_LOG2(DL), .MIN_FRAME(MINF)) dut (
    .clk125(clk), .rst(rst),
    .ENA_IN(ena), .SOF_IN(sof), .EOF_IN(eof), .ERR_IN(err),
    .DATA_IN(din),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_sof(o_sof), .o_eof(o_eof), .o_data(o_data),
    .drop_pulse(drop_pulse)
`ifdef GMAC_RX_FRAME_BUF_STAT_EN
    , .frames_ok(frames_ok), .frames_drop(frames_drop)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];
  int exp_drops = 0;
  int seen_drops = 0;
  bit partial_open = 0;
  int rmode = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // consumer ready pattern
  initial begin
    i_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: i_ready = 1'b1;
        1: i_ready = 1'b0;
        2: i_ready = ~i_ready;
        default: i_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // output monitor: scoreboard, hold-while-stalled, drop count
  initial begin
    bit prev_stall;
    logic [10:0] prev_w;
    logic [9:0] e;
    prev_stall = 0;
    prev_w = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (drop_pulse) seen_drops++;
        if (prev_stall)
          chk("hold", 32'({o_valid, o_sof, o_eof, o_data}), 32'(prev_w));
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_byte", 32'({o_valid, o_sof, o_eof, o_data}), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("byte", 32'({o_sof, o_eof, o_data}), 32'(e));
          end
        end
        prev_stall = o_valid && !i_ready;
        prev_w = {o_valid, o_sof, o_eof, o_data};
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_byte(bit s, bit e, bit r, logic [7:0] d);
    ena = 1'b1; sof = s; eof = e; err = r; din = d;
    @(posedge clk);
    #1;
    ena = 1'b0; sof = 1'b0; eof = 1'b0; err = 1'b0;
    din = 8'($urandom);
  endtask

  // frame-level model: a closed frame is kept iff error-free, long
  // enough and fitting the free space; an open frame dies at next SOF
  task automatic send_frame(int len, bit bad, bit close, int gapmax);
    logic [7:0] d[$];
    logic [7:0] b;
    int space;
    if (partial_open) begin
      exp_drops++;
      partial_open = 0;
    end
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      d.push_back(b);
      drive_byte(i == 0, close && i == len - 1,
                 bad && close && i == len - 1, b);
      if (gapmax > 0 && i < len - 1) idle($urandom_range(0, gapmax));
    end
    if (!close) begin
      partial_open = 1;
    end else begin
      space = DEPTH - exp_q.size();
      if (bad || len < MINF || len > space) begin
        exp_drops++;
      end else begin
        for (int i = 0; i < len; i++)
          exp_q.push_back({i == 0, i == len - 1, d[i]});
      end
    end
  endtask

  task automatic drain(string tag, int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
    chk({tag, "_drops"}, 32'(seen_drops), 32'(exp_drops));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int len;
    bit bad, close;
    rst = 1'b1; ena = 1'b0; sof = 1'b0; eof = 1'b0; err = 1'b0;
    din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_sof", 32'(o_sof), 32'd0);
    chk("rst_eof", 32'(o_eof), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_drop", 32'(drop_pulse), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // 64-byte good frame: latency N+3 and contiguous output
    send_frame(64, 0, 1, 0);
    @(negedge clk);
    chk("lat_n1", 32'(o_valid), 32'd0);
    @(negedge clk);
    chk("lat_n2", 32'(o_valid), 32'd0);
    @(negedge clk);
    chk("lat_n3", 32'(o_valid), 32'd1);
    for (int i = 0; i < 63; i++) begin
      @(negedge clk);
      chk("contig", 32'(o_valid), 32'd1);
    end
    drain("t1", 100);

    // CRC-bad frame followed by good frame
    send_frame(64, 1, 1, 0);
    send_frame(10, 0, 1, 0);
    drain("t2", 100);

    // overflow while consumer stalled
    rmode = 1;
    send_frame(40, 0, 1, 1);
    send_frame(40, 0, 1, 0);
    idle(5);
    rmode = 0;
    drain("t3", 200);

    // missing EOF: new SOF abandons the open frame
    send_frame(20, 0, 0, 0);
    send_frame(8, 0, 1, 0);
    drain("t4", 100);

    // alternating ready over a 100-byte frame
    rmode = 2;
    send_frame(100 > DEPTH ? DEPTH : 100, 0, 1, 0);
    drain("t5", 400);
    rmode = 0;

    // minimum-length boundary, single-beat SOF+EOF frame
    send_frame(MINF - 1, 0, 1, 0);
    send_frame(MINF, 0, 1, 0);
    send_frame(1, 0, 1, 0);
    drain("t6", 100);

    // reset mid-frame with a committed frame still buffered
    rmode = 1;
    send_frame(10, 0, 1, 0);
    send_frame(5, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    partial_open = 0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    rmode = 0;
    send_frame(12, 0, 1, 0);
    drain("t7", 100);
`ifdef GMAC_RX_FRAME_BUF_STAT_EN
    chk("stat_ok", frames_ok, 32'd1);
    chk("stat_drop", frames_drop, 32'd0);
`endif

    // random frames, errors, missing EOFs, gaps and back-pressure
    for (int f = 0; f < 40; f++) begin
      for (int w = 0; w < 300; w++) begin
        if (exp_q.size() <= 20) break;
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      rmode = (f % 3 == 0) ? 0 : ((f % 3 == 1) ? 2 : 3);
      len = $urandom_range(1, 20);
      if (partial_open && len < 2) len = 2;
      bad = ($urandom_range(0, 7) == 0);
      close = ($urandom_range(0, 9) != 0) || (f == 39);
      send_frame(len, bad, close, $urandom_range(0, 2));
    end
    drain("rand", 2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
